fib_phase_sequencer: RTL and testbench

//  Control stage directly upstream of the Fibonacci ALU. Accepts a request for fib(N),

---
 rtl/fib_phase_sequencer.sv | 82 ++++++++
 tb/tb_fib_phase_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fib_phase_sequencer.sv
// fib_phase_sequencer: Fetch/Exec1/Exec2 phase control for the Fibonacci ALU.
// Optional iteration watchdog enabled by defining FIB_WATCHDOG_EN.
module fib_phase_sequencer #(
    parameter int DATA_W = 16,
    parameter int ITER_W = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = 16'd24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n_in,
    input  logic              abort,
    input  logic              cond_met,
    input  logic [DATA_W-1:0] fbcv_reg,
    output logic [DATA_W-1:0] fbc_th_value,
    output logic              fetch,
    output logic              exec1,
    output logic              exec2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ITER_W-1:0] iter_count,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, DONE} state_t;
    state_t state, state_nx;
    logic wd_trip;
    logic [ITER_W-1:0] iter_inc;
    assign iter_inc = iter_count + {{(ITER_W-1){1'b0}}, ~&iter_count};
`ifdef FIB_WATCHDOG_EN
    assign wd_trip = !cond_met &&
                     ({1'b0, iter_count} + {{ITER_W{1'b0}}, 1'b1} >= {1'b0, MAX_ITER});
`else
    logic unused_max_iter;
    assign unused_max_iter = ^MAX_ITER;
    assign wd_trip = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = EXEC1;
            EXEC1:   state_nx = EXEC2;
            EXEC2:   state_nx = cond_met ? DONE : (wd_trip ? IDLE : FETCH);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end
    // Phase strobes are flops loaded from the next state so they align with state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            fetch        <= 1'b0;
            exec1        <= 1'b0;
            exec2        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fbc_th_value <= '0;
            result       <= '0;
            iter_count   <= '0;
            error        <= 1'b0;
        end else begin
            state <= state_nx;
            fetch <= state_nx == FETCH;
            exec1 <= state_nx == EXEC1;
            exec2 <= state_nx == EXEC2;
            busy  <= state_nx != IDLE;
            done  <= state_nx == DONE;
            if (state == IDLE && start) begin
                fbc_th_value <= n_in;
                iter_count   <= '0;
                error        <= 1'b0;
            end
            if (state == EXEC2 && !abort) begin
                iter_count <= iter_inc;
                if (cond_met) result <= fbcv_reg;
                else if (wd_trip) error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fib_phase_sequencer.sv
// tb_fib_phase_sequencer: directed self-checking bench for fib_phase_sequencer.
module tb_fib_phase_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] n_in = '0;
    logic        abort = 1'b0;
    logic        cond_met = 1'b0;
    logic [15:0] fbcv_reg = '0;
    logic [15:0] fbc_th_value, result, iter_count;
    logic        fetch, exec1, exec2, busy, done, error;
    int checks = 0;
    int failures = 0;

    fib_phase_sequencer #(.DATA_W(16), .ITER_W(16), .MAX_ITER(16'd4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .n_in(n_in), .abort(abort),
        .cond_met(cond_met), .fbcv_reg(fbcv_reg), .fbc_th_value(fbc_th_value),
        .fetch(fetch), .exec1(exec1), .exec2(exec2), .busy(busy), .done(done),
        .result(result), .iter_count(iter_count), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {fetch,exec1,exec2,done,busy} expected in cycle c of a request finishing at cycle d
    function automatic logic [4:0] phase_exp(input int c, input int d);
        if (c == d) return 5'b00011;
        case ((c - 1) % 3)
            0:       return 5'b10001;
            1:       return 5'b01001;
            default: return 5'b00101;
        endcase
    endfunction

    function automatic logic [31:0] phases();
        return {27'd0, fetch, exec1, exec2, done, busy};
    endfunction

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_phases", phases(), 0);
        chk("rst_result", result, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_th", fbc_th_value, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        tick();
        // reset asserted mid-EXEC1 returns to reset values asynchronously
        start = 1'b1; n_in = 16'd7;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_exec1", phases(), 5'b01001);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_phases", phases(), 0);
        chk("async_rst_th", fbc_th_value, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_phases", phases(), 0);
        // N=1 base case: done 4 cycles after start
        start = 1'b1; n_in = 16'd1; cond_met = 1'b1; fbcv_reg = 16'h0001;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("n1_phase_c%0d", c), phases(), phase_exp(c, 4));
            if (c < 4) tick();
        end
        chk("n1_result", result, 16'h0001);
        chk("n1_iter", iter_count, 1);
        chk("n1_th", fbc_th_value, 1);
        tick();
        chk("n1_idle", phases(), 0);
        // N=10: cond_met only in 9th EXEC2, stray start in cycle 5, noise on cond_met/fbcv_reg
        start = 1'b1; n_in = 16'd10;
        cond_met = 1'b1; fbcv_reg = 16'hdead;
        tick();
        start = 1'b0; n_in = 16'd0;
        for (int c = 1; c <= 28; c++) begin
            chk($sformatf("n10_phase_c%0d", c), phases(), phase_exp(c, 28));
            chk($sformatf("n10_iter_c%0d", c), iter_count, (c - 1) / 3);
            chk($sformatf("n10_th_c%0d", c), fbc_th_value, 10);
            if (c < 28) chk($sformatf("n10_res_hold_c%0d", c), result, 16'h0001);
            cond_met = (c % 3 != 0) || (c == 27);
            fbcv_reg = (c == 27) ? 16'd55 : 16'hdead;
            start = (c == 5);
            n_in = (c == 5) ? 16'd3 : 16'd0;
            if (c < 28) tick();
        end
        chk("n10_result", result, 16'd55);
        chk("n10_iter", iter_count, 9);
        // start while in DONE is ignored
        start = 1'b1; n_in = 16'd3;
        tick();
        start = 1'b0;
        chk("n10_done_start_ignored", phases(), 0);
        chk("n10_th_final", fbc_th_value, 10);
        // abort in the 2nd EXEC1
        cond_met = 1'b0; fbcv_reg = 16'hbeef;
        start = 1'b1; n_in = 16'd5;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("abort_phase_c%0d", c), phases(), phase_exp(c, 99));
            if (c < 5) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_phases", phases(), 0);
        chk("abort_iter", iter_count, 1);
        chk("abort_result", result, 16'd55);
        chk("abort_th", fbc_th_value, 5);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("abort_quiet_%0d", c), phases(), 0);
        end
        // abort alone in IDLE does nothing; abort+start in IDLE accepts start
        abort = 1'b1;
        tick();
        chk("abort_idle", phases(), 0);
        start = 1'b1; n_in = 16'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_fetch", phases(), 5'b10001);
        chk("abort_start_th", fbc_th_value, 2);
        chk("abort_start_iter", iter_count, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_fetch", phases(), 0);
`ifdef FIB_WATCHDOG_EN
        // watchdog with MAX_ITER=4: trips after the 4th EXEC2
        cond_met = 1'b0;
        start = 1'b1; n_in = 16'd20;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("wd_phase_c%0d", c), phases(), phase_exp(c, 99));
            chk($sformatf("wd_err_c%0d", c), error, 0);
            tick();
        end
        chk("wd_phases", phases(), 0);
        chk("wd_error", error, 1);
        chk("wd_iter", iter_count, 4);
        chk("wd_result", result, 16'd55);
        tick();
        chk("wd_error_hold", error, 1);
        start = 1'b1; n_in = 16'd1;
        tick();
        start = 1'b0;
        chk("wd_error_clear", error, 0);
        chk("wd_restart", phases(), 5'b10001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        // no watchdog: runs well past MAX_ITER with error held 0
        cond_met = 1'b0;
        start = 1'b1; n_in = 16'd20;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c % 10 == 0) begin
                chk($sformatf("nowd_phase_c%0d", c), phases(), phase_exp(c, 99));
                chk($sformatf("nowd_err_c%0d", c), error, 0);
            end
            if (c < 30) tick();
        end
        chk("nowd_iter", iter_count, 9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("nowd_abort", phases(), 0);
        chk("nowd_error", error, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
